// File: rtl/btn_cmd_conditioner_pkg.sv
// Shared constants for the front-panel button path: command codes, button indices.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_cmd_conditioner_pkg;

  localparam int CMD_W = 3;
  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_NONE   = 3'd0;
  localparam cmd_t CMD_UP     = 3'd1;
  localparam cmd_t CMD_DOWN   = 3'd2;
  localparam cmd_t CMD_LEFT   = 3'd3;
  localparam cmd_t CMD_RIGHT  = 3'd4;
  localparam cmd_t CMD_CENTER = 3'd5;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  // Button index i maps onto command code i+1 (CMD_UP for index 0, ...).
  function automatic cmd_t btn_idx_to_cmd(input int unsigned idx);
    return cmd_t'(idx + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-level debouncer.
// Latency: 2 cycles sync + DEB_CNT cycles of unchanged input before level_o follows.
// Backpressure: none; free-running per-bit filter.
// Ports: clk/rst (async active-high), btn_i raw async level, level_o debounced level.
module btn_debounce #(
  parameter int DEB_CNT = 50000,
  parameter int DEB_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any return to the accepted level restarts the count, so a new level must
  // be seen for DEB_CNT consecutive cycles before it is accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/btn_cmd_conditioner.sv
// Debounces the front-panel buttons and turns each press into a buffered move command.
// Latency: press held from cycle 0 gives cmd_valid at cycle DEB_CNT+4 (2 sync, DEB_CNT, 1 edge, 1 buffer).
// Backpressure: one-entry buffer drained by cmd_valid/cmd_ack; presses arriving while it is full are dropped.
// Ports: clk, rst (async active-high), btn raw levels, cmd_ack consumer take,
//        cmd_valid/cmd_code buffered command, btn_level debounced levels, drop discard pulse.
module btn_cmd_conditioner
  import btn_cmd_conditioner_pkg::*;
#(
  parameter int N_BTN   = 5,
  parameter int DEB_CNT = 50000,
  parameter int DEB_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic             cmd_ack,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_code,
  output logic [N_BTN-1:0] btn_level,
  output logic             drop
);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;

  cmd_t win_code;
  logic multi_press;
  logic take;

  logic valid_q;
  logic valid_d;
  cmd_t code_q;
  cmd_t code_d;
  logic drop_q;
  logic drop_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_deb
    btn_debounce #(
      .DEB_CNT(DEB_CNT),
      .DEB_W  (DEB_W)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn[i]),
      .level_o(stable[i])
    );
  end

  // level_q doubles as the edge-detect history and the debounced level output.
  assign press_d = stable & ~level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      press_q <= '0;
      valid_q <= 1'b0;
      code_q  <= CMD_NONE;
      drop_q  <= 1'b0;
    end else begin
      level_q <= stable;
      press_q <= press_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      drop_q  <= drop_d;
    end
  end

  // Lowest set index wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    win_code = CMD_NONE;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_q[i]) begin
        win_code = btn_idx_to_cmd(i);
      end
    end
  end

  // More than one bit set means the non-winning presses are discarded.
  assign multi_press = |(press_q & (press_q - N_BTN'(1)));
  assign take        = valid_q & cmd_ack;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    drop_d  = multi_press;
    if (|press_q) begin
      if (!valid_q || take) begin
        // Reload in the ack cycle itself, so back-to-back commands have no bubble.
        valid_d = 1'b1;
        code_d  = win_code;
      end else begin
        drop_d = 1'b1;
      end
    end else if (take) begin
      valid_d = 1'b0;
      code_d  = CMD_NONE;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;
  assign btn_level = level_q;
  assign drop      = drop_q;

endmodule

// File: doc/btn_cmd_conditioner.md
Name: btn_cmd_conditioner

Overview:
- Upstream conditioning stage for the five front-panel buttons, placed before the puzzle I/O block.
- Synchronises and debounces each raw button, then detects press edges.
- Encodes each press into a single move command and holds it in a one-entry buffer.
- The buffer is drained by the I/O block through a valid/ack handshake.

Parameters:
- N_BTN, 5, number of buttons; bit 0 = up, 1 = down, 2 = left, 3 = right, 4 = center.
- DEB_CNT, 50000, clk cycles a changed input must stay stable before it is accepted (minimum 2).
- DEB_W, 16, debounce counter width; must satisfy 2^DEB_W > DEB_CNT.

Ports:
- clk  input  1  system clock; the single clock of the block.
- rst  input  1  asynchronous, active-high reset.
- btn  input  N_BTN  raw asynchronous button levels, 1 = pressed.
- cmd_ack  input  1  consumer takes the command when this and cmd_valid are both high at a clk edge.
- cmd_valid  output  1  buffered command present.
- cmd_code  output  3  buffered command: 1 up, 2 down, 3 left, 4 right, 5 center; 0 when not valid.
- btn_level  output  N_BTN  debounced button levels.
- drop  output  1  one-cycle pulse: a press was discarded.

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - synchroniser flops, stable levels, counters and edge registers = 0;
  - cmd_valid = 0, cmd_code = 0, btn_level = 0, drop = 0.
  - Reset asserted mid-debounce or with a command pending discards everything; no command appears after release until a fresh press is debounced.
- Synchroniser: two flops per bit; raw to sync latency is 2 cycles.
- Debounce, per bit (independent instances):
  - If sync == stable, the counter is cleared to 0.
  - Else if counter == DEB_CNT-1: stable <= sync and counter <= 0.
  - Else counter increments.
  - Any bounce back to the stable value clears the counter, so the new level must hold for DEB_CNT consecutive cycles.
  - btn_level = stable (registered).
- Edge detect:
  - press[i] is a one-cycle pulse in the cycle after stable[i] goes 0 to 1.
  - Releases produce no command.
- Encode:
  - If any press bit is set, the winner is the lowest set index; code = index + 1.
  - Every other set press bit in the same cycle is discarded and drop pulses.
- Buffer, evaluated each cycle (take = cmd_valid & cmd_ack):
  - take and no press: cmd_valid <= 0, cmd_code <= 0.
  - press and (!cmd_valid or take): load the winner code and set cmd_valid <= 1. Back-to-back is allowed: the ack cycle can reload with no bubble.
  - press while cmd_valid and !take: the old command is kept and the new press is discarded; drop <= 1 for one cycle.
  - cmd_ack while cmd_valid = 0 is ignored.
  - cmd_code and cmd_valid stay constant until taken.
- Latency: a clean press held from cycle 0 gives cmd_valid = 1 at cycle 2 + DEB_CNT + 2 = DEB_CNT + 4.
  - 2 cycles synchroniser, DEB_CNT cycles counting, 1 cycle edge, 1 cycle buffer.
- drop is registered and is 0 in every cycle that has no discarded press.
- Holding a button produces exactly one command; there is no auto-repeat.

Decomposition:
- Shared package contains:
  - command code constants CMD_NONE = 0, CMD_UP = 1, CMD_DOWN = 2, CMD_LEFT = 3, CMD_RIGHT = 4, CMD_CENTER = 5;
  - button index constants;
  - the 3-bit command width.
- The I/O block imports the same package.
- One sub-module, btn_debounce: synchroniser, counter and stable register for a single bit. It is parameterised by DEB_CNT/DEB_W and instantiated N_BTN times.
- Edge detect, encoder and buffer stay in the top of this block.

Test Plan (DEB_CNT = 4 override):
- Reset: assert rst with btn = 5'b11111 -> all outputs 0 immediately; after release they stay 0 until 4 stable cycles have elapsed.
- Clean press: btn[2] rises at cycle 0 and is held -> cmd_valid = 1, cmd_code = 3 at cycle 8; btn_level[2] = 1 one cycle earlier; cmd_ack at cycle 10 -> cmd_valid = 0 at cycle 11. No second command while the button is held.
- Bounce: btn[0] toggles 1,0,1,0 on alternate cycles, then holds 1 -> exactly one command, code 1, issued 8 cycles after the final rising transition; drop stays 0.
- Simultaneous press: btn[1] and btn[3] rise together -> code 2 loaded, drop pulses once, no command 4 follows.
- Buffer full: code 5 pending with cmd_ack low, then btn[0] is pressed -> drop pulses, cmd_code stays 5.
- Back-to-back: cmd_ack in the same cycle as press[3] with code 1 pending -> next cycle cmd_valid = 1, cmd_code = 4, no bubble.
